// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
// Latency: out_valid WIDTH+1 cycles after accept; 1 cycle for divide special cases.
// Backpressure: in_ready=1 only in IDLE, the requester holds in_valid; kill aborts, rst overrides kill.
//
// Ports: clk/rst (synchronous, active-high); in_valid/in_ready request handshake;
//        op (RV32M funct3), a (rs1), b (rs2) sampled on accept; kill flushes any op;
//        out_valid one-cycle strobe; out result register; zero_flag = (out == 0).
// Build option: define ALU_MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle
//        combinational multiply (accept goes straight to DONE). Results are identical.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opb_q, opb_d;       // |b|: multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic               neg_q, neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;

    // Request decode, evaluated on the live inputs for the accept cycle.
    logic             is_div, a_signed, b_signed, a_neg, b_neg;
    logic             b_zero, div_ovf, special, neg_in, accept;
    logic [WIDTH-1:0] a_abs, b_abs;

    always_comb begin
        is_div   = op[2];
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed && a[WIDTH-1];
        b_neg    = b_signed && b[WIDTH-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        // Remainder takes the dividend's sign; everything else the product/quotient sign.
        if (op == OP_REM) begin
            neg_in = a_neg;
        end else if ((op == OP_DIVU) || (op == OP_REMU)) begin
            neg_in = 1'b0;
        end else begin
            neg_in = a_neg ^ b_neg;
        end
        b_zero  = (b == '0);
        div_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1) &&
                  ((op == OP_DIV) || (op == OP_REM));
        special = is_div && (b_zero || div_ovf);
    end

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready && !kill;

    // One iteration of each datapath, plus final sign fix-up and result select.
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   rem_diff, quo_res, rem_res, result;
    logic               rem_ge;
    logic [2*WIDTH-1:0] step_mul, step_div, prod;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        step_mul = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring division: shift the next dividend bit into the partial remainder.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge   = (rem_sh >= {1'b0, opb_q});
        rem_diff = rem_sh[WIDTH-1:0] - opb_q;   // exact whenever rem_ge
        step_div = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};

        // Full-width negate so MULH/MULHSU high halves are exact.
        prod    = neg_q ? -acc_q : acc_q;
        quo_res = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_res = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        result = rem_res;
        case (op_q)
            OP_MUL:                        result = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               result = quo_res;
            default:                       result = rem_res;
        endcase
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = op;
                    opb_d = b_abs;
                    acc_d = {{WIDTH{1'b0}}, a_abs};
                    neg_d = neg_in;
                    cnt_d = '0;
                    if (special) begin
                        // Quotient lives in the low half, remainder in the high half.
                        acc_d   = {(b_zero ? a : {WIDTH{1'b0}}), (b_zero ? {WIDTH{1'b1}} : a)};
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end
`ifdef ALU_MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        acc_d   = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
                        state_d = DONE;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = op_q[2] ? step_div : step_mul;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_d       = result;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush: abort whatever is in flight without touching the result register.
        if (kill) begin
            state_d     = IDLE;
            out_d       = out_q;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zero_flag = (out_q == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv (WIDTH=32).
// Inputs are driven on the falling edge; the monitor samples on the falling edge.
// Expected results come from 64-bit integer arithmetic on the RV32M rules.
module tb_alu_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         kill = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero_flag;
    logic [W-1:0] out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out       (out),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // RV32M reference computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx, sy;
        longint      lx, ly, uy;
        logic [63:0] p;
        logic [31:0] r;
        sx = x;
        sy = y;
        lx = sx;
        ly = sy;
        uy = {32'b0, y};
        r  = '0;
        case (o)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
            3'd1: begin p = lx * ly; r = p[63:32]; end
            3'd2: begin p = lx * uy; r = p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else r = sx / sy;
            end
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
                else r = sx % sy;
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (x == 32'h8000_0000 && y == 32'hFFFF_FFFF && (o == 3'd4 || o == 3'd6))))
            return 1;
`ifdef ALU_MULDIV_FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return W + 1;
    endfunction

    // Called on a falling edge. Leaves in_valid high; returns on the falling edge after accept.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int acc_at);
        int   n;
        exp_t e;
        n = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {63'b0, in_ready}, 64'd1);
            in_valid = 1'b0;
            acc_at = -1;
            return;
        end
        acc_at    = cyc + 1;
        e.res     = ref_op(o, x, y);
        e.lat     = exp_lat(o, x, y);
        e.acc_cyc = acc_at;
        e.op      = o;
        e.a       = x;
        e.b       = y;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic run1(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int c;
        issue(o, x, y, c);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got strobe with out=0x%0h required none", out);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("result op%0d a=%0h b=%0h", e.op, e.a, e.b), out, e.res);
                    chk($sformatf("zero_flag op%0d", e.op), {63'b0, zero_flag}, {63'b0, e.res == 0});
                    chk($sformatf("latency op%0d", e.op), cyc - e.acc_cyc, e.lat);
                end
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            5: return 32'h0 - 32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int c1, c2;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_zero_flag", {63'b0, zero_flag}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic and special cases
        run1(3'd0, 32'd7, 32'hFFFF_FFFD);
        run1(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run1(3'd1, 32'h8000_0000, 32'h8000_0000);
        run1(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run1(3'd4, 32'hFFFF_FFF9, 32'd2);
        run1(3'd6, 32'hFFFF_FFF9, 32'd2);
        run1(3'd5, 32'd7, 32'd2);
        run1(3'd7, 32'd7, 32'd2);
        run1(3'd4, 32'd5, 32'd0);
        run1(3'd7, 32'd5, 32'd0);
        run1(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run1(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run1(3'd5, 32'd7, 32'd2);

        // Kill at cycle 10 of a DIV: out keeps 3
        issue(3'd4, 32'd100, 32'd7, c1);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        void'(sb.pop_back());
        chk("kill_calc_in_ready", {63'b0, in_ready}, 64'd1);
        chk("kill_calc_out_valid", {63'b0, out_valid}, 64'd0);
        chk("kill_calc_out", out, 64'd3);
        repeat (40) @(negedge clk);
        run1(3'd0, 32'd7, 32'hFFFF_FFFD);

        // Kill while in DONE (special-case DIV): no strobe, out unchanged
        op = 3'd4; a = 32'd5; b = 32'd0; in_valid = 1'b1;
        chk("done_accept_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_done_out_valid", {63'b0, out_valid}, 64'd0);
        chk("kill_done_out", out, 64'hFFFF_FFEB);
        chk("kill_done_in_ready", {63'b0, in_ready}, 64'd1);
        repeat (3) @(negedge clk);

        // Kill with in_valid in IDLE: no accept
        op = 3'd4; a = 32'd9; b = 32'd3; in_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        kill = 1'b0;
        chk("kill_idle_no_accept", {63'b0, in_ready}, 64'd1);
        repeat (40) @(negedge clk);

        // Reset at cycle 5 of a DIVU
        issue(3'd5, 32'd1000, 32'd3, c1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        chk("midrst_out", out, 64'd0);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("midrst_zero_flag", {63'b0, zero_flag}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back with in_valid held
        issue(3'd4, 32'hFFFF_FF00, 32'd9, c1);
        issue(3'd5, 32'd12345, 32'd67, c2);
        in_valid = 1'b0;
        chk("b2b_accept_gap", c2 - c1, W + 2);
        drain();

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), c1);
            if ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
